// File: rtl/usb_link_sched.sv
// usb_link_sched
// Link-layer scheduler for a USB 1.1 full-speed pad interface. It owns the
// pad output enable, arbitrates the single serializer between a handshake
// source (high priority) and a data source (low priority), enforces the
// inter-packet gap, and times out a missing bus-turnaround response.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   hs_req_i/hs_pid_i/hs_ack_o   handshake request, PID byte, accept pulse
//   dat_req_i/dat_byte_i/
//   dat_last_i/dat_ack_o         data byte stream and per-byte accept
//   expect_rsp_i                 sampled at data-packet start
//   tx_byte_o/tx_valid_o/
//   tx_last_o/tx_ready_i         byte interface to the serializer
//   tx_busy_i                    serializer still shifting bits or EOP
//   tx_oe_o                      registered pad output enable
//   rx_active_i/rx_eop_i         receiver SYNC detected / EOP pulse
//   timeout_o                    response window expired (one-cycle pulse)
//   state_o                      current state encoding (debug)
module usb_link_sched #(
    parameter int CLK_PER_BIT     = 4,
    parameter int IPG_BITS        = 2,
    parameter int RX_TIMEOUT_BITS = 18
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hs_req_i,
    input  logic [7:0] hs_pid_i,
    output logic       hs_ack_o,
    input  logic       dat_req_i,
    input  logic [7:0] dat_byte_i,
    input  logic       dat_last_i,
    output logic       dat_ack_o,
    input  logic       expect_rsp_i,
    output logic [7:0] tx_byte_o,
    output logic       tx_valid_o,
    output logic       tx_last_o,
    input  logic       tx_ready_i,
    input  logic       tx_busy_i,
    output logic       tx_oe_o,
    input  logic       rx_active_i,
    input  logic       rx_eop_i,
    output logic       timeout_o,
    output logic [2:0] state_o
);

    localparam int GAP_CYC = IPG_BITS * CLK_PER_BIT;
    localparam int RSP_CYC = RX_TIMEOUT_BITS * CLK_PER_BIT;
    localparam int MAX_CYC = (GAP_CYC > RSP_CYC) ? GAP_CYC : RSP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // The counter is loaded with N-1 on entry and the state is left when it
    // reads zero, so the state lasts exactly N cycles.
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] RSP_LOAD = CW'(RSP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_HS  = 3'd1,
        S_SEND_DAT = 3'd2,
        S_DRAIN    = 3'd3,
        S_GAP      = 3'd4,
        S_WAIT_RSP = 3'd5,
        S_RX       = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_pend_q, rsp_pend_d;
    logic [7:0]    pid_q, pid_d;
    logic          oe_q, oe_d;
    logic          timeout_q, timeout_d;

    logic          cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rsp_pend_q <= 1'b0;
            pid_q      <= 8'h00;
            oe_q       <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_pend_q <= rsp_pend_d;
            pid_q      <= pid_d;
            oe_q       <= oe_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_pend_d = rsp_pend_q;
        pid_d      = pid_q;
        timeout_d  = 1'b0;
        tx_valid_o = 1'b0;
        tx_byte_o  = 8'h00;
        tx_last_o  = 1'b0;
        hs_ack_o   = 1'b0;
        dat_ack_o  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_active_i) begin
                    state_d = S_RX;
                end else if (hs_req_i) begin
                    state_d    = S_SEND_HS;
                    pid_d      = hs_pid_i;
                    rsp_pend_d = 1'b0;
                end else if (dat_req_i) begin
                    state_d    = S_SEND_DAT;
                    rsp_pend_d = expect_rsp_i;
                end
            end
            S_SEND_HS: begin
                tx_valid_o = 1'b1;
                tx_byte_o  = pid_q;
                tx_last_o  = 1'b1;
                hs_ack_o   = tx_ready_i;
                if (tx_ready_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_SEND_DAT: begin
                tx_valid_o = dat_req_i;
                tx_byte_o  = dat_byte_i;
                tx_last_o  = dat_last_i;
                dat_ack_o  = dat_req_i & tx_ready_i;
                if (dat_req_i && tx_ready_i && dat_last_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Receiver activity here is our own echo and is ignored.
                if (!tx_busy_i) begin
                    if (rsp_pend_q) begin
                        state_d = S_WAIT_RSP;
                        cnt_d   = RSP_LOAD;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (rx_active_i) begin
                    state_d = S_RX;
                end else if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT_RSP: begin
                if (rx_active_i) begin
                    state_d = S_RX;
                end else if (cnt_zero) begin
                    state_d   = S_GAP;
                    cnt_d     = GAP_LOAD;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RX: begin
                if (rx_eop_i) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output enable tracks the transmit phase one edge ahead so the pad
        // is driven from the first SEND cycle and released leaving DRAIN.
        oe_d = (state_d == S_SEND_HS) || (state_d == S_SEND_DAT) ||
               (state_d == S_DRAIN);
    end

    assign tx_oe_o   = oe_q;
    assign timeout_o = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_usb_link_sched.sv
module tb_usb_link_sched;

    localparam int GAP_N = 8;   // IPG_BITS * CLK_PER_BIT
    localparam int RSP_N = 72;  // RX_TIMEOUT_BITS * CLK_PER_BIT

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       hs_req_i = 1'b0;
    logic [7:0] hs_pid_i = 8'h00;
    logic       hs_ack_o;
    logic       dat_req_i = 1'b0;
    logic [7:0] dat_byte_i = 8'h00;
    logic       dat_last_i = 1'b0;
    logic       dat_ack_o;
    logic       expect_rsp_i = 1'b0;
    logic [7:0] tx_byte_o;
    logic       tx_valid_o;
    logic       tx_last_o;
    logic       tx_ready_i = 1'b0;
    logic       tx_busy_i = 1'b0;
    logic       tx_oe_o;
    logic       rx_active_i = 1'b0;
    logic       rx_eop_i = 1'b0;
    logic       timeout_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    usb_link_sched dut (
        .clk_i(clk), .rst_i(rst_i),
        .hs_req_i(hs_req_i), .hs_pid_i(hs_pid_i), .hs_ack_o(hs_ack_o),
        .dat_req_i(dat_req_i), .dat_byte_i(dat_byte_i), .dat_last_i(dat_last_i),
        .dat_ack_o(dat_ack_o), .expect_rsp_i(expect_rsp_i),
        .tx_byte_o(tx_byte_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
        .tx_ready_i(tx_ready_i), .tx_busy_i(tx_busy_i), .tx_oe_o(tx_oe_o),
        .rx_active_i(rx_active_i), .rx_eop_i(rx_eop_i),
        .timeout_o(timeout_o), .state_o(state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Phase-plus-age view: m_age counts cycles already spent in the phase.
    int       m_st;
    int       m_age;
    bit [7:0] m_pid;
    bit       m_rsp;
    bit       m_oe;
    bit       m_to;

    task model_reset();
        m_st = 0; m_age = 0; m_pid = 8'h00; m_rsp = 1'b0; m_oe = 1'b0; m_to = 1'b0;
    endtask

    task model_step();
        int nst;
        bit to;
        if (rst_i) begin
            model_reset();
            return;
        end
        nst = m_st;
        to  = 1'b0;
        case (m_st)
            0: if (rx_active_i) nst = 6;
               else if (hs_req_i) begin nst = 1; m_pid = hs_pid_i; m_rsp = 1'b0; end
               else if (dat_req_i) begin nst = 2; m_rsp = expect_rsp_i; end
            1: if (tx_ready_i) nst = 3;
            2: if (dat_req_i && tx_ready_i && dat_last_i) nst = 3;
            3: if (!tx_busy_i) nst = m_rsp ? 5 : 4;
            4: if (rx_active_i) nst = 6; else if (m_age + 1 >= GAP_N) nst = 0;
            5: if (rx_active_i) nst = 6; else if (m_age + 1 >= RSP_N) begin nst = 4; to = 1'b1; end
            6: if (rx_eop_i) nst = 4;
            default: nst = 0;
        endcase
        m_to  = to;
        m_age = (nst == m_st) ? m_age + 1 : 0;
        m_st  = nst;
        m_oe  = (nst == 1) || (nst == 2) || (nst == 3);
    endtask

    initial begin : compare
        bit       e_valid, e_last, e_hs, e_dat;
        bit [7:0] e_byte;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst_i) model_reset();
            e_valid = 1'b0; e_last = 1'b0; e_hs = 1'b0; e_dat = 1'b0; e_byte = 8'h00;
            if (m_st == 1) begin
                e_valid = 1'b1; e_byte = m_pid; e_last = 1'b1; e_hs = tx_ready_i;
            end else if (m_st == 2) begin
                e_valid = dat_req_i; e_byte = dat_byte_i; e_last = dat_last_i;
                e_dat = dat_req_i & tx_ready_i;
            end
            chk("m_state", state_o, m_st);
            chk("m_oe", tx_oe_o, m_oe);
            chk("m_timeout", timeout_o, m_to);
            chk("m_valid", tx_valid_o, e_valid);
            chk("m_byte", tx_byte_o, e_byte);
            chk("m_last", tx_last_o, e_last);
            chk("m_hs_ack", hs_ack_o, e_hs);
            chk("m_dat_ack", dat_ack_o, e_dat);
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", state_o, s);
    endtask

    // Counts cycles spent in state s starting from the current cycle.
    task automatic count_state(input logic [2:0] s, output int n, output int to_seen);
        n = 0;
        to_seen = 0;
        while (state_o === s && n < 500) begin
            if (timeout_o) to_seen++;
            n++;
            tick();
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] pkt [3];
        int acks, n, to_seen;
        pkt[0] = 8'hC3; pkt[1] = 8'h01; pkt[2] = 8'h02;

        // Reset state
        repeat (3) tick();
        chk("rst_state", state_o, 3'd0);
        chk("rst_oe", tx_oe_o, 1'b0);
        chk("rst_valid", tx_valid_o, 1'b0);
        rst_i = 1'b0;
        tick();

        // Priority: everything at once goes to RX
        hs_req_i = 1'b1; hs_pid_i = 8'hD2; dat_req_i = 1'b1; rx_active_i = 1'b1;
        tick();
        chk("prio_rx", state_o, 3'd6);
        rx_active_i = 1'b0; rx_eop_i = 1'b1;
        tick();
        rx_eop_i = 1'b0;
        chk("rx_to_gap", state_o, 3'd4);
        wait_state(3'd1, 20);
        chk("hs_byte", tx_byte_o, 8'hD2);
        chk("hs_oe", tx_oe_o, 1'b1);
        tx_ready_i = 1'b1; tx_busy_i = 1'b1;
        #1;
        chk("hs_ack_hi", hs_ack_o, 1'b1);
        tick();
        hs_req_i = 1'b0; dat_req_i = 1'b0; tx_ready_i = 1'b0;
        #1;
        chk("hs_ack_lo", hs_ack_o, 1'b0);
        chk("hs_drain", state_o, 3'd3);
        $display("handshake pid=0x%0h sent", 8'hD2);
        tick(); tick();
        tx_busy_i = 1'b0;
        tick();
        wait_state(3'd0, 20);

        // Data packet, ready every 4th cycle, with echo on the receiver
        dat_req_i = 1'b1; dat_byte_i = pkt[0]; dat_last_i = 1'b0;
        expect_rsp_i = 1'b0; tx_busy_i = 1'b1;
        tick();
        chk("dat_state", state_o, 3'd2);
        chk("dat_oe", tx_oe_o, 1'b1);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                dat_byte_i = pkt[i]; dat_last_i = (i == 2);
                tx_ready_i = (k == 3);
                rx_active_i = 1'($urandom); rx_eop_i = 1'($urandom);
                #1;
                if (dat_ack_o) acks++;
                tick();
            end
        end
        dat_req_i = 1'b0; dat_last_i = 1'b0; tx_ready_i = 1'b0;
        chk("dat_acks", acks, 3);
        chk("dat_drain", state_o, 3'd3);
        for (int k = 0; k < 5; k++) begin
            rx_active_i = 1'(k); rx_eop_i = 1'(~k);
            tick();
            chk("echo_state", state_o, 3'd3);
            chk("echo_oe", tx_oe_o, 1'b1);
        end
        rx_active_i = 1'b0; rx_eop_i = 1'b0; tx_busy_i = 1'b0;
        tick();
        chk("drain_oe_off", tx_oe_o, 1'b0);
        count_state(3'd4, n, to_seen);
        chk("gap_len", n, GAP_N);
        chk("gap_to_idle", state_o, 3'd0);
        $display("data packet of 3 bytes sent, gap=%0d", n);

        // Timeout then response, both single-byte packets expecting a reply
        for (int rsp = 0; rsp < 2; rsp++) begin
            dat_req_i = 1'b1; dat_byte_i = 8'h5A; dat_last_i = 1'b1;
            expect_rsp_i = 1'b1; tx_ready_i = 1'b1; tx_busy_i = 1'b1;
            tick();
            chk("one_ack", dat_ack_o, 1'b1);
            tick();
            dat_req_i = 1'b0; dat_last_i = 1'b0; expect_rsp_i = 1'b0;
            tx_ready_i = 1'b0; tx_busy_i = 1'b0;
            tick();
            chk("wait_state", state_o, 3'd5);
            if (rsp == 0) begin
                count_state(3'd5, n, to_seen);
                chk("wait_len", n, RSP_N);
                chk("to_state", state_o, 3'd4);
                chk("to_pulse", timeout_o, 1'b1);
                tick();
                chk("to_single", timeout_o, 1'b0);
                wait_state(3'd0, 20);
                $display("data packet sent, response window expired after %0d cycles", n);
            end else begin
                to_seen = 0;
                for (int c = 0; c < 40; c++) begin
                    if (timeout_o) to_seen++;
                    tick();
                end
                rx_active_i = 1'b1;
                tick();
                rx_active_i = 1'b0;
                chk("rsp_rx", state_o, 3'd6);
                tick(); tick();
                rx_eop_i = 1'b1;
                tick();
                rx_eop_i = 1'b0;
                count_state(3'd4, n, acks);
                chk("rsp_no_to", to_seen + acks, 0);
                chk("rsp_gap_len", n, GAP_N);
                chk("rsp_idle", state_o, 3'd0);
                $display("data packet sent, response received");
            end
        end

        // Asynchronous reset in the middle of a data packet
        dat_req_i = 1'b1; dat_byte_i = 8'h77; tx_busy_i = 1'b1;
        tick();
        chk("ar_pre_state", state_o, 3'd2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("ar_oe", tx_oe_o, 1'b0);
        chk("ar_state", state_o, 3'd0);
        chk("ar_valid", tx_valid_o, 1'b0);
        chk("ar_byte", tx_byte_o, 8'h00);
        tick();
        rst_i = 1'b0; dat_req_i = 1'b0; tx_busy_i = 1'b0;
        tick();
        $display("async reset mid-packet released the bus");

        // Randomized traffic checked by the model every cycle
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 2000; c++) begin
                hs_req_i     = ($urandom_range(0, 3) == 0);
                hs_pid_i     = 8'($urandom);
                dat_req_i    = ($urandom_range(0, 1) == 0);
                dat_byte_i   = 8'($urandom);
                dat_last_i   = ($urandom_range(0, 3) == 0);
                expect_rsp_i = ($urandom_range(0, 1) == 0);
                tx_ready_i   = ($urandom_range(0, 1) == 0);
                tx_busy_i    = ($urandom_range(0, 2) == 0);
                rx_active_i  = (ph == 0) ? ($urandom_range(0, 15) == 0)
                                         : ($urandom_range(0, 199) == 0);
                rx_eop_i     = ($urandom_range(0, 7) == 0);
                rst_i        = ($urandom_range(0, 499) == 0);
                tick();
            end
            $display("random phase %0d done", ph);
        end
        rst_i = 1'b0; hs_req_i = 1'b0; dat_req_i = 1'b0; rx_active_i = 1'b0;
        rx_eop_i = 1'b0; tx_ready_i = 1'b0; tx_busy_i = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
